// File: rtl/i2c_slave_if.sv
// ---------------------------------------------------------------------------
// i2c_slave_if
// Host-side bundle of the I2C target. The open-drain SDA pin and the SCK pin
// stay plain ports on the target because they are board pins, not host bus.
//
// Signals:
//   tx_data    host -> target  byte returned on a read, sampled at tx_req
//   rx_data    target -> host  last byte received in a write transfer
//   rx_valid   target -> host  one-clk strobe when rx_data is updated
//   tx_req     target -> host  one-clk strobe when tx_data was loaded
//   addressed  target -> host  high from the address ACK until the transfer ends
//   i2c_int_n  target -> host  active-low, one clk, coincident with a strobe
//   state_dbg  target -> host  current FSM state, for checkers and debug
//
// Strobe contract: rx_valid and tx_req are single-clk pulses with no back
// pressure. The host must present the next tx_data before the next tx_req.
// ---------------------------------------------------------------------------
interface i2c_slave_if;
   logic [7:0] tx_data;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       tx_req;
   logic       addressed;
   logic       i2c_int_n;
   logic [2:0] state_dbg;

   // The target drives the strobes and status.
   modport slave (
      input  tx_data,
      output rx_data, rx_valid, tx_req, addressed, i2c_int_n, state_dbg
   );

   // The host consumes them and supplies read data.
   modport master (
      output tx_data,
      input  rx_data, rx_valid, tx_req, addressed, i2c_int_n, state_dbg
   );
endinterface

// File: rtl/i2c_slave.sv
// ---------------------------------------------------------------------------
// i2c_slave
// I2C target at a fixed 7-bit address. SDA and SCK are oversampled on clk,
// START/STOP are detected on the synchronised copies, write bytes are handed
// to the host with rx_valid and read bytes are fetched from it with tx_req.
// The block never stretches SCK and only ever pulls SDA low or releases it.
//
// Ports:
//   clk    system clock; each SCK phase lasts at least 8 clk
//   rst_n  synchronous active-low reset
//   sda    open-drain data line (driven 0 or released)
//   sck    bus clock from the master
//   host   i2c_slave_if.slave host-side bundle
// ---------------------------------------------------------------------------
module i2c_slave #(
   parameter logic [6:0] ADDR = 7'h50
) (
   input  logic        clk,
   input  logic        rst_n,
   inout  wire         sda,
   input  logic        sck,
   i2c_slave_if.slave  host
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_ADDR     = 3'd1,
      S_ADDR_ACK = 3'd2,
      S_RX       = 3'd3,
      S_RX_ACK   = 3'd4,
      S_TX       = 3'd5,
      S_TX_ACK   = 3'd6
   } state_t;

   // Input conditioning: two synchroniser flops plus one history flop each.
   logic sda_meta, sda_sync, sda_prev;
   logic sck_meta, sck_sync, sck_prev;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sda_meta <= 1'b1;
         sda_sync <= 1'b1;
         sda_prev <= 1'b1;
         sck_meta <= 1'b1;
         sck_sync <= 1'b1;
         sck_prev <= 1'b1;
      end else begin
         sda_meta <= sda;
         sda_sync <= sda_meta;
         sda_prev <= sda_sync;
         sck_meta <= sck;
         sck_sync <= sck_meta;
         sck_prev <= sck_sync;
      end
   end

   logic sck_rise, sck_fall, start_det, stop_det;
   assign sck_rise  =  sck_sync & ~sck_prev;
   assign sck_fall  = ~sck_sync &  sck_prev;
   // SDA may only move while SCK is low; a move with SCK high in both
   // samples is a bus condition rather than data.
   assign start_det =  sda_prev & ~sda_sync & sck_sync & sck_prev;
   assign stop_det  = ~sda_prev &  sda_sync & sck_sync & sck_prev;

   // Registered state and datapath.
   state_t     state, state_n;
   logic [2:0] bit_cnt, bit_cnt_n;
   logic [7:0] shift, shift_n;
   logic [7:0] rx_data, rx_data_n;
   logic       phase, phase_n;      // per-state sub-step flag, see FSM
   logic       rw, rw_n;
   logic       sda_low, sda_low_n;
   logic       addressed, addressed_n;
   logic       rx_valid, rx_valid_n;
   logic       tx_req, tx_req_n;

   logic [7:0] shift_in;
   assign shift_in = {shift[6:0], sda_sync};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         bit_cnt   <= 3'd7;
         shift     <= 8'h00;
         rx_data   <= 8'h00;
         phase     <= 1'b0;
         rw        <= 1'b0;
         sda_low   <= 1'b0;
         addressed <= 1'b0;
         rx_valid  <= 1'b0;
         tx_req    <= 1'b0;
      end else begin
         state     <= state_n;
         bit_cnt   <= bit_cnt_n;
         shift     <= shift_n;
         rx_data   <= rx_data_n;
         phase     <= phase_n;
         rw        <= rw_n;
         sda_low   <= sda_low_n;
         addressed <= addressed_n;
         rx_valid  <= rx_valid_n;
         tx_req    <= tx_req_n;
      end
   end

   // phase meaning by state:
   //   ADDR_ACK: ACK is being driven (first fall seen)
   //   RX / TX : all 8 data bits have been clocked (8th rise seen)
   //   TX_ACK  : master ACK sampled, reload at next fall
   always_comb begin
      state_n     = state;
      bit_cnt_n   = bit_cnt;
      shift_n     = shift;
      rx_data_n   = rx_data;
      phase_n     = phase;
      rw_n        = rw;
      sda_low_n   = sda_low;
      addressed_n = addressed;
      rx_valid_n  = 1'b0;
      tx_req_n    = 1'b0;

      if (start_det) begin
         // Also covers repeated START; any byte in flight is dropped.
         state_n     = S_ADDR;
         bit_cnt_n   = 3'd7;
         phase_n     = 1'b0;
         sda_low_n   = 1'b0;
         addressed_n = 1'b0;
      end else if (stop_det) begin
         state_n     = S_IDLE;
         phase_n     = 1'b0;
         sda_low_n   = 1'b0;
         addressed_n = 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               sda_low_n = 1'b0;
            end

            S_ADDR: begin
               if (sck_rise) begin
                  shift_n = shift_in;
                  if (bit_cnt == 3'd0) begin
                     if (shift_in[7:1] == ADDR) begin
                        state_n = S_ADDR_ACK;
                        rw_n    = shift_in[0];
                        phase_n = 1'b0;
                     end else begin
                        state_n = S_IDLE;
                     end
                  end else begin
                     bit_cnt_n = bit_cnt - 3'd1;
                  end
               end
            end

            S_ADDR_ACK: begin
               if (sck_fall) begin
                  if (!phase) begin
                     sda_low_n   = 1'b1;
                     addressed_n = 1'b1;
                     phase_n     = 1'b1;
                  end else begin
                     phase_n   = 1'b0;
                     bit_cnt_n = 3'd7;
                     if (!rw) begin
                        sda_low_n = 1'b0;
                        state_n   = S_RX;
                     end else begin
                        shift_n   = host.tx_data;
                        tx_req_n  = 1'b1;
                        sda_low_n = ~host.tx_data[7];
                        state_n   = S_TX;
                     end
                  end
               end
            end

            S_RX: begin
               if (sck_rise) begin
                  shift_n = shift_in;
                  if (bit_cnt == 3'd0) begin
                     phase_n = 1'b1;
                  end else begin
                     bit_cnt_n = bit_cnt - 3'd1;
                  end
               end else if (sck_fall && phase) begin
                  // The byte is only published once the ACK is committed.
                  rx_data_n  = shift;
                  rx_valid_n = 1'b1;
                  sda_low_n  = 1'b1;
                  phase_n    = 1'b0;
                  state_n    = S_RX_ACK;
               end
            end

            S_RX_ACK: begin
               if (sck_fall) begin
                  sda_low_n = 1'b0;
                  bit_cnt_n = 3'd7;
                  state_n   = S_RX;
               end
            end

            S_TX: begin
               if (sck_rise) begin
                  if (bit_cnt == 3'd0) begin
                     phase_n = 1'b1;
                  end else begin
                     bit_cnt_n = bit_cnt - 3'd1;
                  end
               end else if (sck_fall) begin
                  if (phase) begin
                     sda_low_n = 1'b0;
                     phase_n   = 1'b0;
                     state_n   = S_TX_ACK;
                  end else begin
                     // A 1 bit is sent by releasing the line.
                     shift_n   = {shift[6:0], 1'b0};
                     sda_low_n = ~shift[6];
                  end
               end
            end

            S_TX_ACK: begin
               if (sck_rise) begin
                  if (sda_sync) begin
                     addressed_n = 1'b0;
                     state_n     = S_IDLE;
                  end else begin
                     phase_n = 1'b1;
                  end
               end else if (sck_fall && phase) begin
                  phase_n   = 1'b0;
                  shift_n   = host.tx_data;
                  tx_req_n  = 1'b1;
                  sda_low_n = ~host.tx_data[7];
                  bit_cnt_n = 3'd7;
                  state_n   = S_TX;
               end
            end

            default: begin
               state_n   = S_IDLE;
               sda_low_n = 1'b0;
            end
         endcase
      end
   end

   assign sda = sda_low ? 1'b0 : 1'bz;

   assign host.rx_data   = rx_data;
   assign host.rx_valid  = rx_valid;
   assign host.tx_req    = tx_req;
   assign host.addressed = addressed;
   // Both strobes are flops and never coincide, so this stays a clean pulse.
   assign host.i2c_int_n = ~(rx_valid | tx_req);
   assign host.state_dbg = state;

endmodule

// File: tb/tb_i2c_slave.sv
// ---------------------------------------------------------------------------
// tb_i2c_slave
// Bench for i2c_slave: a bit-banged I2C master drives SCK and SDA, a monitor
// collects host strobes, and each scenario task compares what the bus and the
// host saw against expectations derived from I2C transfer rules.
// ---------------------------------------------------------------------------
module tb_i2c_slave;
   localparam logic [6:0] ADDR = 7'h50;
   localparam int Q = 6;   // quarter SCK period in clk; each SCK phase is 2*Q

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic sck   = 1'b1;
   logic m_low = 1'b0;     // master pulls SDA low

   wire sda;
   pullup (sda);
   assign sda = m_low ? 1'b0 : 1'bz;

   i2c_slave_if host ();

   i2c_slave #(.ADDR(ADDR)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .sda   (sda),
      .sck   (sck),
      .host  (host.slave)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- bookkeeping ----------------
   int errors = 0;
   int checks = 0;
   int rx_cnt, tx_cnt, int_cnt, slave_low_cnt, addr_rise, proto_err;
   logic addr_prev;
   logic [7:0] exp_q[$];     // bytes the host should receive
   logic [7:0] got_rx[$];    // bytes the host did receive
   logic [7:0] tx_src[$];    // bytes the host offers for reads

   // Monitor: samples on the falling clk edge, away from DUT updates.
   initial begin
      proto_err = 0;
      addr_prev = 1'b0;
      host.tx_data = 8'h00;
      forever begin
         @(negedge clk);
         if (host.rx_valid) begin
            rx_cnt++;
            got_rx.push_back(host.rx_data);
         end
         if (host.tx_req) begin
            tx_cnt++;
            if (tx_src.size() > 0) void'(tx_src.pop_front());
         end
         host.tx_data = (tx_src.size() > 0) ? tx_src[0] : 8'h00;
         if (!host.i2c_int_n) int_cnt++;
         if ((!host.i2c_int_n) != (host.rx_valid || host.tx_req)) proto_err++;
         if (host.rx_valid && host.tx_req) proto_err++;
         if (sda === 1'b0 && !m_low) slave_low_cnt++;
         if (host.addressed && !addr_prev) addr_rise++;
         addr_prev = host.addressed;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clear_stats();
      rx_cnt = 0; tx_cnt = 0; int_cnt = 0; slave_low_cnt = 0; addr_rise = 0;
      got_rx.delete();
      exp_q.delete();
   endtask

   task automatic bus_start();
      m_low = 1'b0; wait_clk(Q);
      sck = 1'b1;   wait_clk(Q);
      m_low = 1'b1; wait_clk(Q);
      sck = 1'b0;   wait_clk(Q);
   endtask

   task automatic bus_stop();
      m_low = 1'b1; wait_clk(Q);
      sck = 1'b1;   wait_clk(Q);
      m_low = 1'b0; wait_clk(2 * Q);
   endtask

   task automatic write_bit(input logic b);
      m_low = ~b;  wait_clk(Q);
      sck = 1'b1;  wait_clk(2 * Q);
      sck = 1'b0;  wait_clk(Q);
   endtask

   task automatic read_bit(output logic b);
      m_low = 1'b0; wait_clk(Q);
      sck = 1'b1;   wait_clk(Q);
      b = sda;      wait_clk(Q);
      sck = 1'b0;   wait_clk(Q);
   endtask

   // ack output: 0 = acknowledged
   task automatic write_byte(input logic [7:0] d, output logic ack);
      for (int i = 7; i >= 0; i--) write_bit(d[i]);
      read_bit(ack);
   endtask

   task automatic read_byte(output logic [7:0] d, input logic nack);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         read_bit(b);
         d[i] = b;
      end
      write_bit(nack);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      wait_clk(4);
      checks++; if (host.rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h expected 00", host.rx_data); end
      checks++; if (host.rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b expected 0", host.rx_valid); end
      checks++; if (host.tx_req !== 1'b0) begin errors++; $display("FAIL reset_tx_req: got %b expected 0", host.tx_req); end
      checks++; if (host.addressed !== 1'b0) begin errors++; $display("FAIL reset_addressed: got %b expected 0", host.addressed); end
      checks++; if (host.i2c_int_n !== 1'b1) begin errors++; $display("FAIL reset_int_n: got %b expected 1", host.i2c_int_n); end
      checks++; if (sda !== 1'b1) begin errors++; $display("FAIL reset_sda: got %b expected 1", sda); end
      rst_n = 1'b1;
      wait_clk(8);
   endtask

   task automatic test_write();
      logic a0, a1, a2, addr_mid;
      logic [7:0] e;
      clear_stats();
      exp_q.push_back(8'h3C);
      exp_q.push_back(8'hC3);
      bus_start();
      write_byte(8'hA0, a0);
      write_byte(8'h3C, a1);
      write_byte(8'hC3, a2);
      addr_mid = host.addressed;
      bus_stop();
      checks++; if (a0 !== 1'b0) begin errors++; $display("FAIL wr_addr_ack: got %b expected 0", a0); end
      checks++; if (a1 !== 1'b0) begin errors++; $display("FAIL wr_byte1_ack: got %b expected 0", a1); end
      checks++; if (a2 !== 1'b0) begin errors++; $display("FAIL wr_byte2_ack: got %b expected 0", a2); end
      checks++; if (addr_mid !== 1'b1) begin errors++; $display("FAIL wr_addressed_mid: got %b expected 1", addr_mid); end
      checks++; if (host.addressed !== 1'b0) begin errors++; $display("FAIL wr_addressed_stop: got %b expected 0", host.addressed); end
      checks++; if (rx_cnt != 2) begin errors++; $display("FAIL wr_rx_count: got %0d expected 2", rx_cnt); end
      checks++; if (int_cnt != 2) begin errors++; $display("FAIL wr_int_cycles: got %0d expected 2", int_cnt); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (got_rx.size() == 0) begin errors++; $display("FAIL wr_rx_data: got nothing expected %h", e); end
         else if (got_rx[0] !== e) begin errors++; $display("FAIL wr_rx_data: got %h expected %h", got_rx[0], e); void'(got_rx.pop_front()); end
         else void'(got_rx.pop_front());
      end
   endtask

   task automatic test_nack_addr();
      logic [7:0] probe [2];
      logic ack, ack2;
      probe[0] = 8'hA2;   // 0x51, neighbour of our address
      probe[1] = 8'h00;   // general call
      for (int k = 0; k < 2; k++) begin
         clear_stats();
         bus_start();
         write_byte(probe[k], ack);
         write_byte(8'h5A, ack2);
         bus_stop();
         checks++; if (ack !== 1'b1) begin errors++; $display("FAIL nack_addr_%0d: got ack %b expected 1", k, ack); end
         checks++; if (ack2 !== 1'b1) begin errors++; $display("FAIL nack_data_%0d: got ack %b expected 1", k, ack2); end
         checks++; if (slave_low_cnt != 0) begin errors++; $display("FAIL nack_sda_driven_%0d: got %0d cycles expected 0", k, slave_low_cnt); end
         checks++; if (rx_cnt + tx_cnt != 0) begin errors++; $display("FAIL nack_strobes_%0d: got %0d expected 0", k, rx_cnt + tx_cnt); end
         checks++; if (addr_rise != 0) begin errors++; $display("FAIL nack_addressed_%0d: got %0d rises expected 0", k, addr_rise); end
      end
   endtask

   task automatic test_read();
      logic ack, addr_after, sda_after;
      logic [7:0] d0, d1;
      clear_stats();
      tx_src.push_back(8'h96);
      tx_src.push_back(8'h5A);
      wait_clk(2);
      bus_start();
      write_byte(8'hA1, ack);
      read_byte(d0, 1'b0);
      read_byte(d1, 1'b1);
      addr_after = host.addressed;
      sda_after  = sda;
      bus_stop();
      checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rd_addr_ack: got %b expected 0", ack); end
      checks++; if (d0 !== 8'h96) begin errors++; $display("FAIL rd_byte0: got %h expected 96", d0); end
      checks++; if (d1 !== 8'h5A) begin errors++; $display("FAIL rd_byte1: got %h expected 5a", d1); end
      checks++; if (tx_cnt != 2) begin errors++; $display("FAIL rd_tx_req_count: got %0d expected 2", tx_cnt); end
      checks++; if (int_cnt != 2) begin errors++; $display("FAIL rd_int_cycles: got %0d expected 2", int_cnt); end
      checks++; if (addr_after !== 1'b0) begin errors++; $display("FAIL rd_addressed_nack: got %b expected 0", addr_after); end
      checks++; if (sda_after !== 1'b1) begin errors++; $display("FAIL rd_sda_released: got %b expected 1", sda_after); end
   endtask

   task automatic test_repeated_start();
      logic a0, a1, a2;
      logic [7:0] d;
      clear_stats();
      tx_src.push_back(8'h77);
      wait_clk(2);
      bus_start();
      write_byte(8'hA0, a0);
      write_byte(8'h11, a1);
      bus_start();
      write_byte(8'hA1, a2);
      read_byte(d, 1'b1);
      bus_stop();
      checks++; if ({a0, a1, a2} !== 3'b000) begin errors++; $display("FAIL rs_acks: got %b expected 000", {a0, a1, a2}); end
      checks++; if (host.rx_data !== 8'h11 || rx_cnt != 1) begin errors++; $display("FAIL rs_rx: got %h x%0d expected 11 x1", host.rx_data, rx_cnt); end
      checks++; if (d !== 8'h77) begin errors++; $display("FAIL rs_read: got %h expected 77", d); end
      checks++; if (addr_rise != 2) begin errors++; $display("FAIL rs_addr_acks: got %0d expected 2", addr_rise); end
      checks++; if (tx_cnt != 1) begin errors++; $display("FAIL rs_tx_req: got %0d expected 1", tx_cnt); end
   endtask

   task automatic test_stop_midbyte();
      logic a, a1, a2;
      clear_stats();
      bus_start();
      write_byte(8'hA0, a);
      write_bit(1'b0); write_bit(1'b1); write_bit(1'b0); write_bit(1'b1);
      bus_stop();
      checks++; if (rx_cnt != 0) begin errors++; $display("FAIL stop_mid_rx_valid: got %0d expected 0", rx_cnt); end
      checks++; if (host.addressed !== 1'b0) begin errors++; $display("FAIL stop_mid_addressed: got %b expected 0", host.addressed); end
      checks++; if (sda !== 1'b1) begin errors++; $display("FAIL stop_mid_sda: got %b expected 1", sda); end
      clear_stats();
      bus_start();
      write_byte(8'hA0, a1);
      write_byte(8'h42, a2);
      bus_stop();
      checks++; if ({a1, a2} !== 2'b00) begin errors++; $display("FAIL stop_mid_next_acks: got %b expected 00", {a1, a2}); end
      checks++; if (rx_cnt != 1 || got_rx.size() != 1 || got_rx[0] !== 8'h42) begin errors++; $display("FAIL stop_mid_next_rx: got %0d bytes first %h expected 1 byte 42", rx_cnt, host.rx_data); end
   endtask

   task automatic test_reset_ack();
      logic [7:0] a;
      a = 8'hA0;
      bus_start();
      for (int i = 7; i >= 0; i--) write_bit(a[i]);
      m_low = 1'b0;
      wait_clk(1);
      checks++; if (sda !== 1'b0) begin errors++; $display("FAIL rst_ack_driving: got %b expected 0", sda); end
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      checks++; if (sda !== 1'b1) begin errors++; $display("FAIL rst_ack_sda: got %b expected 1", sda); end
      checks++; if (host.addressed !== 1'b0 || host.rx_valid !== 1'b0 || host.tx_req !== 1'b0) begin errors++; $display("FAIL rst_ack_status: got %b%b%b expected 000", host.addressed, host.rx_valid, host.tx_req); end
      checks++; if (host.rx_data !== 8'h00 || host.i2c_int_n !== 1'b1) begin errors++; $display("FAIL rst_ack_outputs: got %h/%b expected 00/1", host.rx_data, host.i2c_int_n); end
      @(negedge clk);
      rst_n = 1'b1;
      wait_clk(Q);
      bus_stop();
   endtask

   // Random transfers judged by the rules: only ADDR is acknowledged; an
   // addressed write hands every byte to the host and ACKs it; an addressed
   // read returns the host bytes in order with one tx_req per byte.
   task automatic test_random();
      for (int t = 0; t < 8; t++) begin
         logic [6:0] a;
         logic       rw, ack, hit;
         logic [7:0] d, e;
         logic [7:0] data[$];
         int         n;
         a = ($urandom_range(0, 1) == 1) ? ADDR : 7'($urandom_range(0, 127));
         rw = 1'($urandom_range(0, 1));
         n = $urandom_range(1, 3);
         hit = (a == ADDR);
         data.delete();
         for (int i = 0; i < n; i++) data.push_back(8'($urandom_range(0, 255)));
         clear_stats();
         if (rw && hit) foreach (data[i]) tx_src.push_back(data[i]);
         wait_clk(2);
         bus_start();
         write_byte({a, rw}, ack);
         checks++; if (ack !== !hit) begin errors++; $display("FAIL rnd%0d_addr_ack: addr %h got %b expected %b", t, a, ack, !hit); end
         if (!rw) begin
            for (int i = 0; i < n; i++) begin
               write_byte(data[i], ack);
               if (hit) exp_q.push_back(data[i]);
               checks++; if (ack !== !hit) begin errors++; $display("FAIL rnd%0d_wr_ack%0d: got %b expected %b", t, i, ack, !hit); end
            end
         end else if (hit) begin
            for (int i = 0; i < n; i++) begin
               read_byte(d, (i == n - 1));
               checks++; if (d !== data[i]) begin errors++; $display("FAIL rnd%0d_rd%0d: got %h expected %h", t, i, d, data[i]); end
            end
         end
         bus_stop();
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (got_rx.size() == 0) begin errors++; $display("FAIL rnd%0d_rx: got nothing expected %h", t, e); end
            else begin
               d = got_rx.pop_front();
               if (d !== e) begin errors++; $display("FAIL rnd%0d_rx: got %h expected %h", t, d, e); end
            end
         end
         checks++; if (got_rx.size() != 0) begin errors++; $display("FAIL rnd%0d_rx_extra: got %0d extra expected 0", t, got_rx.size()); end
         checks++; if (tx_cnt != ((rw && hit) ? n : 0)) begin errors++; $display("FAIL rnd%0d_tx_req: got %0d expected %0d", t, tx_cnt, (rw && hit) ? n : 0); end
         checks++; if (host.addressed !== 1'b0) begin errors++; $display("FAIL rnd%0d_addressed: got %b expected 0", t, host.addressed); end
      end
   endtask

   task automatic test_protocol();
      checks++;
      if (proto_err != 0) begin errors++; $display("FAIL strobe_protocol: got %0d violations expected 0", proto_err); end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_write();
      test_nack_addr();
      test_read();
      test_repeated_start();
      test_stop_midbyte();
      test_reset_ack();
      test_random();
      test_protocol();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
